// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND command/address sequencer.
package nand_seq_pkg;

  localparam int SEQ_BYTE_W     = 8;      // width of one command/address byte
  localparam int T_WB_DEF       = 5;      // default tWB delay in cycles
  localparam int RB_TIMEOUT_DEF = 65535;  // default R/B# wait limit in cycles
  localparam int MAX_ADDR_DEF   = 5;      // default maximum address bytes
  localparam int GUARD_CYC      = 2;      // cycles of ignored busy after an activate

  typedef enum logic [3:0] {
    IDLE,
    CMD1,
    CMD1_WAIT,
    ADDR,
    ADDR_WAIT,
    CMD2,
    CMD2_WAIT,
    TWB,
    RB_WAIT,
    DONE
  } seq_state_t;

  // Select address byte i (byte 0 is the least significant, sent first).
  function automatic logic [SEQ_BYTE_W-1:0] addr_byte(input logic [39:0] a,
                                                      input logic [2:0]  i);
    case (i)
      3'd0:    addr_byte = a[7:0];
      3'd1:    addr_byte = a[15:8];
      3'd2:    addr_byte = a[23:16];
      3'd3:    addr_byte = a[31:24];
      3'd4:    addr_byte = a[39:32];
      default: addr_byte = '0;
    endcase
  endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// R/B# two-flop synchroniser. With NAND_RB_TIMEOUT_EN it also hosts the
// counter that bounds how long the sequencer sits waiting for ready.
module nand_rb_sync
`ifdef NAND_RB_TIMEOUT_EN
  import nand_seq_pkg::*;
#(
  parameter int RB_TIMEOUT = RB_TIMEOUT_DEF
)
`endif
(
  input  logic clk,
  input  logic nreset,
  input  logic rb_i,
`ifdef NAND_RB_TIMEOUT_EN
  input  logic cnt_en_i,
  output logic timeout_o,
`endif
  output logic rb_o
);

  logic rb_meta_q, rb_sync_q;

  // Two-stage synchroniser; resets to "busy" so nothing is mistaken for ready.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= rb_i;
      rb_sync_q <= rb_meta_q;
    end
  end

  assign rb_o = rb_sync_q;

`ifdef NAND_RB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(RB_TIMEOUT - 1);

  logic [15:0] cnt_q;

  // Counts cycles spent waiting; cleared whenever the wait is not active.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)               cnt_q <= '0;
    else if (!cnt_en_i)        cnt_q <= '0;
    else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  // Fires on the last permitted wait cycle so the exit lands exactly on the limit.
  assign timeout_o = cnt_en_i && (cnt_q == TO_LAST);
`endif

endmodule

// File: rtl/nand_cmd_sequencer.sv
// NAND command/address transaction sequencer: CMD1, 0..MAX_ADDR address
// bytes, optional CMD2, optional tWB + R/B# wait, then a done pulse.
// Optional feature macro: NAND_RB_TIMEOUT_EN (adds RB_TIMEOUT and rb_error).
module nand_cmd_sequencer
  import nand_seq_pkg::*;
#(
  parameter int T_WB     = T_WB_DEF,
  parameter int MAX_ADDR = MAX_ADDR_DEF
`ifdef NAND_RB_TIMEOUT_EN
  , parameter int RB_TIMEOUT = RB_TIMEOUT_DEF
`endif
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  cmd1,
  input  logic [7:0]  cmd2,
  input  logic        cmd2_en,
  input  logic [2:0]  addr_cnt,
  input  logic [39:0] addr,
  input  logic        wait_rb,
  output logic        cle_activate,
  output logic [15:0] cle_data,
  input  logic        cle_busy,
  output logic        ale_activate,
  output logic [15:0] ale_data,
  input  logic        ale_busy,
  input  logic        nand_rb,
  output logic        busy,
  output logic        done
`ifdef NAND_RB_TIMEOUT_EN
  , output logic      rb_error
`endif
);

  localparam logic [2:0]  MAX_A      = 3'(MAX_ADDR);
  localparam logic [1:0]  GUARD_LAST = 2'(GUARD_CYC);
  localparam logic [15:0] TWB_LAST   = 16'(T_WB - 1);

  seq_state_t            state_q;
  logic [7:0]            cmd1_q, cmd2_q;
  logic                  cmd2_en_q, wait_rb_q;
  logic [39:0]           addr_q;
  logic [2:0]            eff_cnt_q, idx_q;
  logic [1:0]            guard_q;
  logic [15:0]           twb_q;
  logic                  cle_act_q, ale_act_q, done_q;
  logic [SEQ_BYTE_W-1:0] cle_byte_q, ale_byte_q;

  logic [2:0]  eff_cnt_d, idx_d;
  logic        guard_done;
  seq_state_t  chain_st;
  logic        rb_sync;

`ifdef NAND_RB_TIMEOUT_EN
  logic rb_timeout, rb_err_q;

  nand_rb_sync #(.RB_TIMEOUT(RB_TIMEOUT)) u_rb_sync (
    .clk       (clk),
    .nreset    (nreset),
    .rb_i      (nand_rb),
    .cnt_en_i  (state_q == RB_WAIT),
    .timeout_o (rb_timeout),
    .rb_o      (rb_sync)
  );

  assign rb_error = rb_err_q;
`else
  nand_rb_sync u_rb_sync (
    .clk    (clk),
    .nreset (nreset),
    .rb_i   (nand_rb),
    .rb_o   (rb_sync)
  );
`endif

  assign eff_cnt_d  = (addr_cnt > MAX_A) ? MAX_A : addr_cnt;
  assign idx_d      = idx_q + 3'd1;
  assign guard_done = (guard_q == GUARD_LAST);

  // Step that follows CMD1 or the final address byte.
  always_comb begin
    chain_st = DONE;
    if (cmd2_en_q)      chain_st = CMD2;
    else if (wait_rb_q) chain_st = TWB;
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign cle_activate = cle_act_q;
  assign ale_activate = ale_act_q;
  assign cle_data     = {8'h00, cle_byte_q};
  assign ale_data     = {8'h00, ale_byte_q};

  // Sequencer FSM; strobes are registered and set on entry to their state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cmd1_q     <= '0;
      cmd2_q     <= '0;
      cmd2_en_q  <= 1'b0;
      wait_rb_q  <= 1'b0;
      addr_q     <= '0;
      eff_cnt_q  <= '0;
      idx_q      <= '0;
      guard_q    <= '0;
      twb_q      <= '0;
      cle_act_q  <= 1'b0;
      ale_act_q  <= 1'b0;
      cle_byte_q <= '0;
      ale_byte_q <= '0;
      done_q     <= 1'b0;
`ifdef NAND_RB_TIMEOUT_EN
      rb_err_q   <= 1'b0;
`endif
    end else begin
      cle_act_q <= 1'b0;
      ale_act_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          cmd1_q     <= cmd1;
          cmd2_q     <= cmd2;
          cmd2_en_q  <= cmd2_en;
          wait_rb_q  <= wait_rb;
          addr_q     <= addr;
          eff_cnt_q  <= eff_cnt_d;
          idx_q      <= '0;
          cle_act_q  <= 1'b1;
          cle_byte_q <= cmd1;
          state_q    <= CMD1;
`ifdef NAND_RB_TIMEOUT_EN
          rb_err_q   <= 1'b0;
`endif
        end
        CMD1: begin
          guard_q <= '0;
          state_q <= CMD1_WAIT;
        end
        CMD1_WAIT: begin
          if (!guard_done) guard_q <= guard_q + 2'd1;
          else if (!cle_busy) begin
            if (eff_cnt_q != 3'd0) begin
              ale_act_q  <= 1'b1;
              ale_byte_q <= addr_byte(addr_q, 3'd0);
              state_q    <= ADDR;
            end else begin
              state_q   <= chain_st;
              cle_act_q <= (chain_st == CMD2);
              done_q    <= (chain_st == DONE);
              twb_q     <= '0;
              if (chain_st == CMD2) cle_byte_q <= cmd2_q;
            end
          end
        end
        ADDR: begin
          guard_q <= '0;
          state_q <= ADDR_WAIT;
        end
        ADDR_WAIT: begin
          if (!guard_done) guard_q <= guard_q + 2'd1;
          else if (!ale_busy) begin
            idx_q <= idx_d;
            if (idx_d == eff_cnt_q) begin
              state_q   <= chain_st;
              cle_act_q <= (chain_st == CMD2);
              done_q    <= (chain_st == DONE);
              twb_q     <= '0;
              if (chain_st == CMD2) cle_byte_q <= cmd2_q;
            end else begin
              ale_act_q  <= 1'b1;
              ale_byte_q <= addr_byte(addr_q, idx_d);
              state_q    <= ADDR;
            end
          end
        end
        CMD2: begin
          guard_q <= '0;
          state_q <= CMD2_WAIT;
        end
        CMD2_WAIT: begin
          if (!guard_done) guard_q <= guard_q + 2'd1;
          else if (!cle_busy) begin
            twb_q <= '0;
            if (wait_rb_q) state_q <= TWB;
            else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        TWB: begin
          if (twb_q == TWB_LAST) state_q <= RB_WAIT;
          else                   twb_q   <= twb_q + 16'd1;
        end
        RB_WAIT: begin
          if (rb_sync) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`ifdef NAND_RB_TIMEOUT_EN
          else if (rb_timeout) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            rb_err_q <= 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
